// File: rtl/bfl_pkg.sv
// Shared types, defaults and parameter legality check for the bound_flasher_param LED sequencer.
package bfl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP1,
        DN1,
        UP2,
        DN2,
        UP3,
        DN3,
        KB
    } bfl_state_t;

    localparam int BFL_N_LED = 16;
    localparam int BFL_LO    = 5;
    localparam int BFL_HI    = 10;

    // Bounds must satisfy 0 < LO < HI < N_LED; the prescaler must fit a 16-bit count.
    function automatic bit bfl_params_ok(int n_led, int lo, int hi, int step_div);
        return (n_led >= 4) && (n_led <= 64) &&
               (lo > 0) && (lo < hi) && (hi < n_led) &&
               (step_div >= 1) && (step_div <= 65535);
    endfunction

endpackage

// File: rtl/bfl_step_div.sv
// Step-rate prescaler: tick is high on the last clock of every STEP_DIV-clock window.
module bfl_step_div #(
    parameter int STEP_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    // clr holds the window at its start so the first step after a start is a full window away.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt <= '0;
        end else if (clr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: six-phase thermometer LED sequence with kickback, prescaler and status.
// Optional bar mirroring is enabled by defining BFL_MIRROR_EN.
module bound_flasher_param
    import bfl_pkg::*;
#(
    parameter int N_LED    = BFL_N_LED,
    parameter int LO       = BFL_LO,
    parameter int HI       = BFL_HI,
    parameter int STEP_DIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLICK,
`ifdef BFL_MIRROR_EN
    input  logic             MIRROR,
`endif
    output logic [N_LED-1:0] LED,
    output logic             BUSY,
    output logic             DONE
);

    localparam int PW = $clog2(N_LED + 1);
    localparam logic [PW-1:0] N_P  = PW'(N_LED);
    localparam logic [PW-1:0] LO_P = PW'(LO);
    localparam logic [PW-1:0] HI_P = PW'(HI);

    if (!bfl_params_ok(N_LED, LO, HI, STEP_DIV)) begin : g_param_check
        $fatal(1, "bound_flasher_param: illegal N_LED/LO/HI/STEP_DIV combination");
    end

    bfl_state_t      state, state_n, ret, ret_n;
    logic [PW-1:0]   pos, pos_n, pos_inc, pos_dec;
    logic            flick_pend, pend_n;
    logic            armed;
    logic            tick, clr, kick, done_n;
    logic [N_LED-1:0] bar, led_n;
`ifdef BFL_MIRROR_EN
    logic            mirror_q, mirror_n;
`endif

    assign pos_inc = pos + 1'b1;
    assign pos_dec = pos - 1'b1;

    bfl_step_div #(.STEP_DIV(STEP_DIV)) u_div (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (clr),
        .tick (tick)
    );

    function automatic logic [PW-1:0] floor_of(bfl_state_t s);
        return (s == UP2) ? LO_P : '0;
    endfunction

    function automatic logic [PW-1:0] target_of(bfl_state_t s);
        case (s)
            UP1:     return N_P;
            DN1:     return LO_P;
            UP2:     return HI_P;
            UP3:     return LO_P;
            default: return '0;
        endcase
    endfunction

    function automatic bfl_state_t next_of(bfl_state_t s);
        case (s)
            UP1:     return DN1;
            DN1:     return UP2;
            UP2:     return DN2;
            DN2:     return UP3;
            UP3:     return DN3;
            default: return IDLE;
        endcase
    endfunction

    // A FLICK on the tick cycle counts for that tick; otherwise it waits in flick_pend until the tick.
    always_comb begin
        state_n = state;
        ret_n   = ret;
        pos_n   = pos;
        pend_n  = flick_pend;
        done_n  = 1'b0;
        clr     = 1'b0;
        kick    = 1'b0;
        if (state == IDLE) begin
            clr    = 1'b1;
            pend_n = 1'b0;
            if (FLICK && armed) begin
                state_n = UP1;
            end
        end else begin
            if (FLICK) begin
                pend_n = 1'b1;
            end
            if (tick) begin
                pend_n = 1'b0;
                kick   = (FLICK || flick_pend) && ((pos == LO_P) || (pos == HI_P)) &&
                         (pos > floor_of(state));
                case (state)
                    UP1, UP2, UP3: begin
                        if (kick) begin
                            ret_n   = state;
                            state_n = KB;
                            pos_n   = pos_dec;
                        end else begin
                            pos_n = pos_inc;
                            if (pos_inc == target_of(state)) begin
                                state_n = next_of(state);
                            end
                        end
                    end
                    DN1, DN2, DN3: begin
                        pos_n = pos_dec;
                        if (pos_dec == target_of(state)) begin
                            state_n = next_of(state);
                            done_n  = (state == DN3);
                        end
                    end
                    KB: begin
                        pos_n = pos_dec;
                        if (pos_dec == floor_of(ret)) begin
                            state_n = ret;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef BFL_MIRROR_EN
    always_comb begin
        mirror_n = mirror_q;
        if ((state == IDLE) && (state_n == UP1)) begin
            mirror_n = MIRROR;
        end
    end
`endif

    // Outputs are decoded from next state/pos so the registered LED/BUSY line up with pos and state.
    always_comb begin
        bar = '0;
        for (int i = 0; i < N_LED; i++) begin
            bar[i] = (PW'(i) < pos_n);
        end
        led_n = bar;
`ifdef BFL_MIRROR_EN
        if (mirror_n) begin
            for (int i = 0; i < N_LED; i++) begin
                led_n[N_LED-1-i] = bar[i];
            end
        end
`endif
    end

    // armed stays low for the first clock after reset so a FLICK there cannot start a sequence.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            ret        <= IDLE;
            pos        <= '0;
            flick_pend <= 1'b0;
            armed      <= 1'b0;
            LED        <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
`ifdef BFL_MIRROR_EN
            mirror_q   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            pos        <= pos_n;
            flick_pend <= pend_n;
            armed      <= 1'b1;
            LED        <= led_n;
            BUSY       <= (state_n != IDLE);
            DONE       <= done_n;
`ifdef BFL_MIRROR_EN
            mirror_q   <= mirror_n;
`endif
        end
    end

endmodule
